// File: rtl/tiny16_pkg.sv
// Shared defaults and helpers for the tiny16 register file.
package tiny16_pkg;

   localparam int WORD_W   = 16;
   localparam int NUM_REGS = 8;
   localparam int PC_IDX   = 0;
   localparam int SP_IDX   = 1;

   localparam logic [WORD_W-1:0] SP_RST = '1;

   typedef enum logic [1:0] {
      SP_HOLD = 2'd0,
      SP_DEC  = 2'd1,
      SP_INC  = 2'd2
   } sp_op_e;

   // push moves the stack down, pop moves it up, both together cancel
   function automatic sp_op_e sp_op(input logic push, input logic pop);
      sp_op_e op;
      op = SP_HOLD;
      if (push && !pop)
         op = SP_DEC;
      else if (pop && !push)
         op = SP_INC;
      return op;
   endfunction

endpackage

// File: rtl/reg_incdec.sv
// Modular increment/decrement next-value logic shared by PC and SP.
module reg_incdec
   import tiny16_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic [WIDTH-1:0] i_val,
   input  logic [WIDTH-1:0] i_step,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [WIDTH-1:0] o_val
);

   always_comb begin
      o_val = i_val;
      if (i_inc && !i_dec)
         o_val = i_val + i_step;
      else if (i_dec && !i_inc)
         o_val = i_val - i_step;
   end

endmodule

// File: rtl/register_file.sv
// General-purpose register file with dedicated PC and SP update paths.
module register_file
   import tiny16_pkg::*;
#(
   parameter int WIDTH    = WORD_W,
   parameter int DEPTH    = NUM_REGS,
   parameter int PC_INDEX = PC_IDX,
   parameter int SP_INDEX = SP_IDX,
   parameter int PC_STEP  = 1,
   parameter int BYPASS   = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(DEPTH)-1:0] src_sel,
   input  logic [$clog2(DEPTH)-1:0] dst_sel,
   input  logic                     in_en,
   input  logic [WIDTH-1:0]         in,
   input  logic                     pc_inc,
   input  logic                     sp_push,
   input  logic                     sp_pop,
   output logic [WIDTH-1:0]         src,
   output logic [WIDTH-1:0]         dst,
   output logic [WIDTH-1:0]         pc,
   output logic [WIDTH-1:0]         sp
);

   logic [WIDTH-1:0] r_gpr [DEPTH];
   logic [WIDTH-1:0] w_pc_nxt;
   logic [WIDTH-1:0] w_sp_nxt;
   sp_op_e           w_sp_op;

   assign w_sp_op = sp_op(sp_push, sp_pop);

   reg_incdec #(.WIDTH(WIDTH)) u_pc_next (
      .i_val  (r_gpr[PC_INDEX]),
      .i_step (WIDTH'(PC_STEP)),
      .i_inc  (pc_inc),
      .i_dec  (1'b0),
      .o_val  (w_pc_nxt)
   );

   reg_incdec #(.WIDTH(WIDTH)) u_sp_next (
      .i_val  (r_gpr[SP_INDEX]),
      .i_step (WIDTH'(1)),
      .i_inc  (w_sp_op == SP_INC),
      .i_dec  (w_sp_op == SP_DEC),
      .o_val  (w_sp_nxt)
   );

   // explicit write is last so it overrides the PC/SP auto-updates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            r_gpr[i] <= (i == SP_INDEX) ? '1 : '0;
      end else begin
         r_gpr[PC_INDEX] <= w_pc_nxt;
         r_gpr[SP_INDEX] <= w_sp_nxt;
         if (in_en)
            r_gpr[dst_sel] <= in;
      end
   end

   logic w_fwd_src;
   logic w_fwd_dst;

   assign w_fwd_src = (BYPASS != 0) && in_en && (src_sel == dst_sel);
   assign w_fwd_dst = (BYPASS != 0) && in_en;

   assign src = w_fwd_src ? in : r_gpr[src_sel];
   assign dst = w_fwd_dst ? in : r_gpr[dst_sel];
   assign pc  = r_gpr[PC_INDEX];
   assign sp  = r_gpr[SP_INDEX];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench: three register_file variants against an array model.
module tb_register_file;

   logic        clk;
   logic        rst;
   logic [2:0]  src_sel;
   logic [2:0]  dst_sel;
   logic        in_en;
   logic [15:0] din;
   logic        pc_inc;
   logic        sp_push;
   logic        sp_pop;

   logic [15:0] src_o [3];
   logic [15:0] dst_o [3];
   logic [15:0] pc_o  [3];
   logic [15:0] sp_o  [3];

   int checks = 0;
   int errors = 0;

   // dut0: defaults, dut1: BYPASS=1, dut2: PC_STEP=2
   register_file u_dut0 (
      .clk(clk), .rst(rst), .src_sel(src_sel), .dst_sel(dst_sel),
      .in_en(in_en), .in(din), .pc_inc(pc_inc), .sp_push(sp_push),
      .sp_pop(sp_pop), .src(src_o[0]), .dst(dst_o[0]),
      .pc(pc_o[0]), .sp(sp_o[0])
   );

   register_file #(.BYPASS(1)) u_dut1 (
      .clk(clk), .rst(rst), .src_sel(src_sel), .dst_sel(dst_sel),
      .in_en(in_en), .in(din), .pc_inc(pc_inc), .sp_push(sp_push),
      .sp_pop(sp_pop), .src(src_o[1]), .dst(dst_o[1]),
      .pc(pc_o[1]), .sp(sp_o[1])
   );

   register_file #(.PC_STEP(2)) u_dut2 (
      .clk(clk), .rst(rst), .src_sel(src_sel), .dst_sel(dst_sel),
      .in_en(in_en), .in(din), .pc_inc(pc_inc), .sp_push(sp_push),
      .sp_pop(sp_pop), .src(src_o[2]), .dst(dst_o[2]),
      .pc(pc_o[2]), .sp(sp_o[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: plain arrays, PC at 0, SP at 1
   logic [15:0] m [3][8];
   int          pstep [3] = '{1, 1, 2};

   typedef struct {
      int          dut;
      int          port;
      logic [15:0] exp;
      string       tag;
   } item_t;

   item_t q[$];

   function automatic void model_reset();
      for (int d = 0; d < 3; d++)
         for (int r = 0; r < 8; r++)
            m[d][r] = (r == 1) ? 16'hFFFF : 16'h0000;
   endfunction

   function automatic void model_step(int d);
      logic [15:0] n [8];
      for (int r = 0; r < 8; r++) n[r] = m[d][r];
      if (pc_inc) n[0] = m[d][0] + 16'(pstep[d]);
      if (sp_push && !sp_pop) n[1] = m[d][1] - 16'd1;
      if (sp_pop && !sp_push) n[1] = m[d][1] + 16'd1;
      if (in_en) n[dst_sel] = din;
      for (int r = 0; r < 8; r++) m[d][r] = n[r];
   endfunction

   function automatic logic [15:0] rd(int d, logic [2:0] s);
      if (d == 1 && in_en && s == dst_sel) return din;
      return m[d][s];
   endfunction

   function automatic void expect_all(string tag);
      for (int d = 0; d < 3; d++) begin
         q.push_back('{d, 0, m[d][0], tag});
         q.push_back('{d, 1, m[d][1], tag});
         q.push_back('{d, 2, rd(d, src_sel), tag});
         q.push_back('{d, 3, rd(d, dst_sel), tag});
      end
   endfunction

   function automatic logic [15:0] dut_out(int d, int p);
      case (p)
         0:       return pc_o[d];
         1:       return sp_o[d];
         2:       return src_o[d];
         default: return dst_o[d];
      endcase
   endfunction

   // monitor: drains each batch one tick after it appears
   initial begin
      item_t       it;
      logic [15:0] act;
      forever begin
         while (q.size() == 0) #1;
         #1;
         while (q.size() != 0) begin
            it  = q.pop_front();
            act = dut_out(it.dut, it.port);
            checks++;
            if (act !== it.exp) begin
               errors++;
               $display("FAIL %s dut%0d port%0d got %h want %h",
                        it.tag, it.dut, it.port, act, it.exp);
            end
         end
      end
   end

   task automatic drive(input logic en, input logic [2:0] ds,
                        input logic [2:0] ss, input logic [15:0] v,
                        input logic pi, input logic pu, input logic po);
      @(negedge clk);
      in_en = en; dst_sel = ds; src_sel = ss; din = v;
      pc_inc = pi; sp_push = pu; sp_pop = po;
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      if (!rst)
         for (int d = 0; d < 3; d++) model_step(d);
      #2;
      expect_all(tag);
   endtask

   task automatic check_now(input string tag);
      #1;
      expect_all(tag);
   endtask

   task automatic wr(input logic [2:0] r, input logic [15:0] v);
      drive(1'b1, r, r, v, 1'b0, 1'b0, 1'b0);
      cycle("setup_wr");
   endtask

   initial begin
      rst = 1'b0; in_en = 1'b0; din = '0; src_sel = 3'd3;
      dst_sel = 3'd0; pc_inc = 1'b0; sp_push = 1'b0; sp_pop = 1'b0;
      for (int d = 0; d < 3; d++)
         for (int r = 0; r < 8; r++) m[d][r] = 'x;

      // asynchronous reset, mid-cycle with no edge
      @(negedge clk);
      #1 rst = 1'b1;
      model_reset();
      check_now("async_reset");
      @(negedge clk);
      rst = 1'b0;

      // PC wrap, and step of 2 on dut2
      wr(3'd0, 16'hFFFE);
      drive(1'b0, 3'd2, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0);
      cycle("pc_inc1");
      cycle("pc_wrap");
      wr(3'd0, 16'h0010);
      drive(1'b0, 3'd2, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0);
      cycle("pc_step");

      // SP push/pop, cancel, and wrap from zero
      wr(3'd1, 16'hFFFF);
      drive(1'b0, 3'd2, 3'd1, 16'h0, 1'b0, 1'b1, 1'b0);
      cycle("push1");
      cycle("push2");
      drive(1'b0, 3'd2, 3'd1, 16'h0, 1'b0, 1'b0, 1'b1);
      cycle("pop1");
      drive(1'b0, 3'd2, 3'd1, 16'h0, 1'b0, 1'b1, 1'b1);
      cycle("push_pop");
      wr(3'd1, 16'h0000);
      drive(1'b0, 3'd2, 3'd1, 16'h0, 1'b0, 1'b1, 1'b0);
      cycle("sp_wrap");

      // explicit write beats increment / SP update
      drive(1'b1, 3'd0, 3'd0, 16'h1234, 1'b1, 1'b0, 1'b0);
      cycle("pc_write_wins");
      drive(1'b1, 3'd1, 3'd1, 16'h4321, 1'b0, 1'b1, 1'b0);
      cycle("sp_write_wins");

      // bypass: same-cycle on dut1, after edge on the others
      drive(1'b1, 3'd5, 3'd5, 16'hABCD, 1'b0, 1'b0, 1'b0);
      check_now("bypass_same");
      cycle("bypass_after");

      // independent r4 write, pc_inc and pop
      drive(1'b1, 3'd4, 3'd4, 16'h5555, 1'b1, 1'b0, 1'b1);
      cycle("triple");

      // reset over pending updates, then normal first edge
      drive(1'b1, 3'd2, 3'd3, 16'h7777, 1'b1, 1'b1, 1'b0);
      #1 rst = 1'b1;
      model_reset();
      check_now("midop_reset");
      cycle("reset_edge");
      drive(1'b0, 3'd2, 3'd3, 16'h0, 1'b1, 1'b0, 1'b1);
      rst = 1'b0;
      cycle("post_reset");

      for (int i = 0; i < 300; i++) begin
         drive(($urandom % 2) == 1, 3'($urandom), 3'($urandom),
               16'($urandom), ($urandom % 2) == 1,
               ($urandom % 3) == 0, ($urandom % 3) == 0);
         check_now("rand_comb");
         cycle("rand_seq");
      end

      for (int t = 0; t < 50 && q.size() != 0; t++) #1;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16: data width of every register in bits.
REQ-002 The block SHALL take parameter DEPTH, default 8: number of registers (power of two, 4..32).
REQ-003 The block SHALL take parameter PC_INDEX, default 0: index of the program-counter register.
REQ-004 The block SHALL take parameter SP_INDEX, default 1: index of the stack-pointer register (must differ from PC_INDEX).
REQ-005 The block SHALL take parameter PC_STEP, default 1: increment applied to PC on pc_inc.
REQ-006 The block SHALL take parameter BYPASS, default 0: 1 = write-through forwarding onto the read ports.
REQ-007 The block SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-009 The block SHALL have ports src_sel and dst_sel, input, SELW = clog2(DEPTH) bits each: read-port selects.
REQ-010 The block SHALL have ports in_en (input, 1 bit) and in (input, WIDTH bits): write enable and write data, written to gpr[dst_sel].
REQ-011 The block SHALL have ports pc_inc, sp_push and sp_pop, input, 1 bit each: PC increment, SP decrement and SP increment requests.
REQ-012 The block SHALL have ports src and dst, output, WIDTH bits each: contents of gpr[src_sel] and gpr[dst_sel].
REQ-013 The block SHALL have ports pc and sp, output, WIDTH bits each: direct views of gpr[PC_INDEX] and gpr[SP_INDEX].

Function
REQ-014 Reads SHALL be combinational, with zero-cycle latency from a select change.
REQ-015 With BYPASS=0, reads SHALL return registered contents: a value written at edge N is visible after edge N.
REQ-016 With BYPASS=1 and in_en=1, a read port whose select equals dst_sel SHALL return in in the same cycle; pc and sp views SHALL NOT be bypassed.
REQ-017 With in_en=1, gpr[dst_sel] SHALL load in at the rising edge.
REQ-018 With pc_inc=1, PC SHALL load PC+PC_STEP modulo 2^WIDTH; all-ones+1 wraps to 0.
REQ-019 With sp_push=1 and sp_pop=0, SP SHALL load SP-1 modulo 2^WIDTH; 0 wraps to all-ones.
REQ-020 With sp_pop=1 and sp_push=0, SP SHALL load SP+1 modulo 2^WIDTH.
REQ-021 With sp_push=1 and sp_pop=1 together, SP SHALL hold its value.
REQ-022 When in_en targets PC in the same cycle as pc_inc, the explicit write SHALL win and the increment is dropped.
REQ-023 When in_en targets SP in the same cycle as push or pop, the explicit write SHALL win.
REQ-024 pc_inc, the SP update and a write to a third register in the same cycle SHALL all take effect independently.
REQ-025 The block SHALL NOT have a hard-wired zero register; every index SHALL be writable.

Reset
REQ-026 While rst=1, all registers SHALL reset immediately (asynchronously) to 0, except SP, which resets to all-ones.
REQ-027 After reset, the outputs SHALL read as src=dst=pc=0 for selects at non-SP indices, and sp=all-ones.
REQ-028 Reset asserted mid-operation SHALL override any write, increment or SP update in the same cycle.
REQ-029 After rst deasserts, the first rising edge SHALL perform normal updates.

Structure
REQ-030 Shared package tiny16_pkg SHALL hold the defaults WORD_W=16, NUM_REGS=8, PC_IDX=0, SP_IDX=1 and the SP reset constant (all-ones).
REQ-031 The block SHALL contain one sub-module, reg_incdec: WIDTH-wide next-value logic taking step, inc and dec, which is used for both PC and SP.
REQ-032 The storage array and write-priority mux SHALL stay in register_file.

Verification (WIDTH=16, DEPTH=8, defaults unless noted)
REQ-033 The bench SHALL apply a reset pulse mid-cycle, with no clock edge -> pc=0000, sp=FFFF, src(sel=3)=0000 immediately.
REQ-034 The bench SHALL set pc=FFFE, then pulse pc_inc for 2 cycles -> FFFF then 0000 (wrap); with PC_STEP=2 from 0010 -> 0012.
REQ-035 The bench SHALL set sp=FFFF and apply push x2, pop x1 -> FFFE, FFFD, FFFE; push and pop together -> unchanged; push at 0000 -> FFFF.
REQ-036 The bench SHALL apply in_en=1, dst_sel=0, in=1234 with pc_inc=1 -> pc=1234, with no increment.
REQ-037 With BYPASS=1, the bench SHALL apply in_en=1, dst_sel=src_sel=5, in=ABCD -> src=ABCD in the same cycle; with BYPASS=0 -> src=ABCD only after the edge.
REQ-038 The bench SHALL apply a simultaneous write r4=5555, pc_inc and sp_pop -> r4=5555, pc+1 and sp+1 all after one edge.
